// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and a
// compile-time clog2 helper.
package barrel_shifter_pkg;

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_LSR = 2'b10;
  localparam logic [1:0] MODE_ASR = 2'b11;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One pipeline stage of the barrel shifter: conditional shift/rotate by 2^K,
// stage register and valid/advance handshake. Optional zero flag is built when
// BARREL_SHIFTER_PIPE_ZERO_FLAG_EN is defined.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = 3,
  parameter int K  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic [W-1:0]  data_in,
  input  logic [SW-1:0] amt_in,
  input  logic [1:0]    mode_in,
  input  logic          sign_in,
  input  logic          adv_next,
  output logic          adv,
  output logic          valid,
  output logic [W-1:0]  data,
  output logic [SW-1:0] amt,
  output logic [1:0]    mode,
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
  output logic          zero,
`endif
  output logic          sign
);

  localparam int S = 1 << K;

  logic          valid_reg;
  logic [W-1:0]  data_reg;
  logic [SW-1:0] amt_reg;
  logic [1:0]    mode_reg;
  logic          sign_reg;
  logic [W-1:0]  shifted;
  logic [W-1:0]  data_next;

  // ASR fills from the sign carried alongside the data, not from data_in's MSB.
  always_comb begin
    shifted = data_in;
    case (mode_in)
      MODE_ROR: shifted = {data_in[S-1:0], data_in[W-1:S]};
      MODE_ROL: shifted = {data_in[W-S-1:0], data_in[W-1:W-S]};
      MODE_LSR: shifted = {{S{1'b0}}, data_in[W-1:S]};
      MODE_ASR: shifted = {{S{sign_in}}, data_in[W-1:S]};
      default:  shifted = data_in;
    endcase
  end

  assign data_next = amt_in[K] ? shifted : data_in;
  assign adv       = !valid_reg | adv_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      amt_reg   <= '0;
      mode_reg  <= '0;
      sign_reg  <= 1'b0;
    end else if (adv) begin
      valid_reg <= valid_in;
      data_reg  <= data_next;
      amt_reg   <= amt_in;
      mode_reg  <= mode_in;
      sign_reg  <= sign_in;
    end
  end

`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
  logic zero_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_reg <= 1'b0;
    end else if (adv) begin
      zero_reg <= valid_in & (data_next == '0);
    end
  end

  assign zero = zero_reg;
`endif

  assign valid = valid_reg;
  assign data  = data_reg;
  assign amt   = amt_reg;
  assign mode  = mode_reg;
  assign sign  = sign_reg;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter with valid/ready backpressure, one stage per shift
// bit. Defining BARREL_SHIFTER_PIPE_ZERO_FLAG_EN adds the y_zero output.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        a,
  input  logic [clog2(W)-1:0] amt,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
  output logic                y_zero,
`endif
  output logic [W-1:0]        y
);

  localparam int SW = clog2(W);

  // Index gi is the input side of stage gi; index SW is the pipe output.
  logic          valid_w [SW+1];
  logic [W-1:0]  data_w  [SW+1];
  logic [SW-1:0] amt_w   [SW+1];
  logic [1:0]    mode_w  [SW+1];
  logic          sign_w  [SW+1];
  logic          adv_w   [SW+1];

  assign valid_w[0] = in_valid;
  assign data_w[0]  = a;
  assign amt_w[0]   = amt;
  assign mode_w[0]  = mode;
  assign sign_w[0]  = a[W-1];
  assign adv_w[SW]  = out_ready;

`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
  logic [SW-1:0] zero_w;
  logic          unused_zero;
  assign y_zero      = zero_w[SW-1];
  assign unused_zero = ^zero_w;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi = gi + 1) begin : g_stage
      barrel_shift_stage #(
        .W  (W),
        .SW (SW),
        .K  (gi)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_w[gi]),
        .data_in  (data_w[gi]),
        .amt_in   (amt_w[gi]),
        .mode_in  (mode_w[gi]),
        .sign_in  (sign_w[gi]),
        .adv_next (adv_w[gi+1]),
        .adv      (adv_w[gi]),
        .valid    (valid_w[gi+1]),
        .data     (data_w[gi+1]),
        .amt      (amt_w[gi+1]),
        .mode     (mode_w[gi+1]),
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
        .zero     (zero_w[gi]),
`endif
        .sign     (sign_w[gi+1])
      );
    end
  endgenerate

  // Sideband that leaves the last stage has no consumer.
  logic unused_tail;
  assign unused_tail = ^{amt_w[SW], mode_w[SW], sign_w[SW]};

  assign in_ready  = adv_w[0] & !reset;
  assign out_valid = valid_w[SW];
  assign y         = data_w[SW];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe (W=8 and W=16 instances); covers
// y_zero when BARREL_SHIFTER_PIPE_ZERO_FLAG_EN is defined.
module tb_barrel_shifter_pipe;

  logic clk;
  logic reset;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] a8, y8;
  logic [2:0] amt8;
  logic [1:0] mode8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, y16;
  logic [3:0]  amt16;
  logic [1:0]  mode16;

`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
  logic y_zero8, y_zero16;
`endif

  int total = 0;
  int bad = 0;

  barrel_shifter_pipe #(.W(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .amt       (amt8),
    .mode      (mode8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
    .y_zero    (y_zero8),
`endif
    .y         (y8)
  );

  barrel_shifter_pipe #(.W(16)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .amt       (amt16),
    .mode      (mode16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
    .y_zero    (y_zero16),
`endif
    .y         (y16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference built from wide shifts on a 32-bit temporary.
  function automatic logic [15:0] ref_shift(input logic [15:0] x, input int n,
                                            input logic [1:0] m, input int w);
    logic [31:0] t;
    logic [31:0] mask;
    logic [31:0] r;
    mask = (w == 16) ? 32'h0000_FFFF : 32'h0000_00FF;
    t = {16'h0, x} & mask;
    case (m)
      2'b00:   r = ((t >> n) | (t << (w - n))) & mask;
      2'b01:   r = ((t << n) | (t >> (w - n))) & mask;
      2'b10:   r = t >> n;
      default: r = (t >> n) | (t[w-1] ? (mask & ~(mask >> n)) : 32'h0);
    endcase
    return r[15:0];
  endfunction

  task automatic send8(input logic [7:0] x, input logic [2:0] n, input logic [1:0] m,
                       input logic [7:0] e);
    out_ready8 = 1'b1;
    in_valid8 = 1'b1;
    a8 = x;
    amt8 = n;
    mode8 = m;
    #1;
    check("accept8_ready", {15'h0, in_ready8}, 16'h1);
    tick;
    in_valid8 = 1'b0;
    tick;
    check("lat8_not_yet", {15'h0, out_valid8}, 16'h0);
    tick;
    check("lat8_valid", {15'h0, out_valid8}, 16'h1);
    check("y8", {8'h0, y8}, {8'h0, e});
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
    check("y_zero8", {15'h0, y_zero8}, {15'h0, (e == 8'h00)});
`endif
    $display("send8 a=%02h amt=%0d mode=%0d y=%02h expected=%02h", x, n, m, y8, e);
    tick;
  endtask

  task automatic send16(input logic [15:0] x, input logic [3:0] n, input logic [1:0] m,
                        input logic [15:0] e);
    out_ready16 = 1'b1;
    in_valid16 = 1'b1;
    a16 = x;
    amt16 = n;
    mode16 = m;
    tick;
    in_valid16 = 1'b0;
    repeat (2) tick;
    check("lat16_not_yet", {15'h0, out_valid16}, 16'h0);
    tick;
    check("lat16_valid", {15'h0, out_valid16}, 16'h1);
    check("y16", y16, e);
    $display("send16 a=%04h amt=%0d mode=%0d y=%04h expected=%04h", x, n, m, y16, e);
    tick;
  endtask

  // Streams n items (value base+i) with out_ready held low for the first hold cycles.
  task automatic stream(input int n, input int hold, input int base);
    logic [7:0] q[$];
    logic [7:0] exp_y;
    logic [7:0] y_prev;
    logic       held;
    logic       accepted;
    logic       ready_at_stall_end;
    int sent;
    int got;
    int cyc;
    int acc_stall;
    int v;
    sent = 0;
    got = 0;
    cyc = 0;
    acc_stall = 0;
    held = 1'b0;
    y_prev = 8'h0;
    ready_at_stall_end = 1'b1;
    while ((sent < n || got < n) && cyc < 1000) begin
      v = base + sent;
      out_ready8 = (cyc >= hold);
      in_valid8 = (sent < n);
      a8 = 8'(v);
      amt8 = 3'(v % 8);
      mode8 = 2'(v % 4);
      #1;
      if (held) check("stall_y_stable", {8'h0, y8}, {8'h0, y_prev});
      if (out_valid8 && out_ready8) begin
        if (q.size() == 0) begin
          check("stream_extra_result", {8'h0, y8}, 16'hDEAD);
        end else begin
          exp_y = q.pop_front();
          check("stream_y", {8'h0, y8}, {8'h0, exp_y});
          $display("stream out #%0d y=%02h expected=%02h", got, y8, exp_y);
        end
        got++;
      end
      accepted = in_valid8 & in_ready8;
      if (accepted && cyc < hold) acc_stall++;
      if (cyc == hold - 1) ready_at_stall_end = in_ready8;
      held = out_valid8 & !out_ready8;
      y_prev = y8;
      tick;
      if (accepted) begin
        q.push_back(ref_shift({8'h0, 8'(v)}, v % 8, 2'(v % 4), 8)[7:0]);
        sent++;
      end
      cyc++;
    end
    check("stream_in_budget", {15'h0, (cyc < 1000)}, 16'h1);
    check("stream_count", 16'(got), 16'(n));
    check("stream_left_over", 16'(q.size()), 16'h0);
    if (hold == 0) begin
      check("stream_throughput_cycles", 16'(cyc), 16'(n + 3));
    end else begin
      check("stall_accepts", 16'(acc_stall), 16'h3);
      check("stall_in_ready", {15'h0, ready_at_stall_end}, 16'h0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick;
  endtask

  initial begin
    reset = 1'b1;
    in_valid8 = 1'b0;
    out_ready8 = 1'b0;
    a8 = 8'h0;
    amt8 = 3'h0;
    mode8 = 2'h0;
    in_valid16 = 1'b0;
    out_ready16 = 1'b0;
    a16 = 16'h0;
    amt16 = 4'h0;
    mode16 = 2'h0;
    repeat (2) tick;
    check("rst_in_ready", {15'h0, in_ready8}, 16'h0);
    check("rst_out_valid", {15'h0, out_valid8}, 16'h0);
    check("rst_y", {8'h0, y8}, 16'h0);
    check("rst_out_valid16", {15'h0, out_valid16}, 16'h0);
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
    check("rst_y_zero", {15'h0, y_zero8}, 16'h0);
`endif
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {15'h0, in_ready8}, 16'h1);
    tick;

    send8(8'h96, 3'd3, 2'b00, 8'hD2);
    send8(8'h96, 3'd3, 2'b01, 8'hB4);
    send8(8'h96, 3'd3, 2'b10, 8'h12);
    send8(8'h96, 3'd3, 2'b11, 8'hF2);

    stream(256, 0, 0);
    stream(10, 5, 100);

    send16(16'h8001, 4'd15, 2'b11, 16'hFFFF);
    send16(16'h8001, 4'd15, 2'b10, 16'h0001);
    send16(16'h8001, 4'd15, 2'b01, 16'hC000);
    for (int m = 0; m < 4; m++) send16(16'h8001, 4'd0, 2'(m), 16'h8001);

    // Reset with two items in flight.
    out_ready8 = 1'b1;
    in_valid8 = 1'b1;
    a8 = 8'h55;
    amt8 = 3'd1;
    mode8 = 2'b00;
    tick;
    a8 = 8'hAA;
    tick;
    in_valid8 = 1'b0;
    reset = 1'b1;
    tick;
    check("midrst_out_valid", {15'h0, out_valid8}, 16'h0);
    check("midrst_in_ready", {15'h0, in_ready8}, 16'h0);
    check("midrst_y", {8'h0, y8}, 16'h0);
    reset = 1'b0;
    #1;
    check("midrst_in_ready_after", {15'h0, in_ready8}, 16'h1);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("midrst_no_ghost", {15'h0, out_valid8}, 16'h0);
    end
    $display("mid-stream reset: out_valid=%0d in_ready=%0d", out_valid8, in_ready8);

`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
    send8(8'h01, 3'd1, 2'b10, 8'h00);
    send8(8'h01, 3'd1, 2'b00, 8'h80);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
